// File: rtl/shift_restore_pkg.sv
// Shared colour/shift types and constants for the shift-restore datapath.
// Latency: n/a (types only). Backpressure: n/a.
// Included by shift_restore and restore_alu.
package shift_restore_pkg;

    localparam int N_COLOR_TO_SHIFTED = 2;

    typedef logic [7:0] color_t;
    typedef logic [$bits(color_t)+N_COLOR_TO_SHIFTED-1:0] shifted_t;
    typedef logic [1:0] shift_val_t;

    typedef enum logic [1:0] {
        RIGHT = 2'd0,
        LEFT  = 2'd1,
        ZERO  = 2'd2
    } shift_dir_t;

    typedef struct packed {
        shift_dir_t dir;
        shift_val_t val;
    } shifter_t;

    localparam color_t MIN_COLOR = 8'h00;
    localparam color_t MAX_COLOR = 8'hFF;

    // Headroom for the largest inverse left shift (<< 3) so nothing wraps before clamping.
    localparam int WIDE_W = $bits(shifted_t) + 3;
    typedef logic [WIDE_W-1:0] wide_t;

endpackage

// File: rtl/restore_alu.sv
// Combinational inverse of the forward colour shift, with clamp to MAX_COLOR.
// Latency: 0 cycles. Backpressure: none (pure function of its inputs).
// SHIFT_RESTORE_ROUND_EN selects round-half-up on the LEFT-inverse path (default: truncate).
module restore_alu
    import shift_restore_pkg::*;
(
    input  shifted_t din,
    input  shifter_t param,
    input  logic     en,
    output color_t   color,
    output logic     sat
);

    wide_t din_w;
    wide_t wide;
    logic  zero;

    assign din_w = {3'b000, din};

    always_comb begin
        wide = din_w;
        zero = 1'b0;
        if (en) begin
            case (param.dir)
                RIGHT: begin
                    wide = din_w << param.val;
                end
                LEFT: begin
                    // Forward LEFT only encodes 1..2; other amounts pass through unshifted.
                    if (param.val == 2'd1 || param.val == 2'd2) begin
`ifdef SHIFT_RESTORE_ROUND_EN
                        wide = (din_w + (wide_t'(1) << (param.val - 2'd1))) >> param.val;
`else
                        wide = din_w >> param.val;
`endif
                    end
                end
                default: begin
                    zero = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        sat   = 1'b0;
        color = MIN_COLOR;
        if (!zero) begin
            sat   = (wide > wide_t'(MAX_COLOR));
            color = sat ? MAX_COLOR : wide[$bits(color_t)-1:0];
        end
    end

endmodule

// File: rtl/shift_restore.sv
// Restores shifted colour samples through a two-stage valid/ready pipeline and counts clamps.
// Latency: 2 cycles input-to-output with no stall; bubbles collapse.
// Backpressure: holds outputs while out_ready=0 and accepts at most 2 samples. Uses restore_alu.
module shift_restore
    import shift_restore_pkg::*;
#(
    parameter int SAT_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  shifted_t             in_data,
    input  shifter_t             in_param,
    input  logic                 in_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output color_t               out_color,
    output logic                 out_sat,
    output logic [SAT_CNT_W-1:0] sat_cnt,
    input  logic                 sat_clr
);

    logic                 s1_vld_q,   s1_vld_d;
    shifted_t             s1_dat_q,   s1_dat_d;
    shifter_t             s1_prm_q,   s1_prm_d;
    logic                 s1_en_q,    s1_en_d;
    logic                 s2_vld_q,   s2_vld_d;
    color_t               s2_color_q, s2_color_d;
    logic                 s2_sat_q,   s2_sat_d;
    logic [SAT_CNT_W-1:0] sat_cnt_q,  sat_cnt_d;

    color_t alu_color;
    logic   alu_sat;
    logic   s2_load;
    logic   s1_adv;
    logic   in_rdy;
    logic   in_fire;
    logic   out_fire;

    restore_alu u_alu (
        .din   (s1_dat_q),
        .param (s1_prm_q),
        .en    (s1_en_q),
        .color (alu_color),
        .sat   (alu_sat)
    );

    assign s2_load  = ~s2_vld_q | out_ready;
    assign s1_adv   = s1_vld_q & s2_load;
    assign in_rdy   = ~s1_vld_q | s1_adv;
    assign in_fire  = in_valid & in_rdy;
    assign out_fire = s2_vld_q & out_ready;

    always_comb begin
        s1_vld_d   = s1_vld_q;
        s1_dat_d   = s1_dat_q;
        s1_prm_d   = s1_prm_q;
        s1_en_d    = s1_en_q;
        s2_vld_d   = s2_vld_q;
        s2_color_d = s2_color_q;
        s2_sat_d   = s2_sat_q;
        sat_cnt_d  = sat_cnt_q;

        if (in_fire) begin
            s1_vld_d = 1'b1;
            s1_dat_d = in_data;
            s1_prm_d = in_param;
            s1_en_d  = in_en;
        end else if (s1_adv) begin
            s1_vld_d = 1'b0;
        end

        if (s2_load) begin
            s2_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                s2_color_d = alu_color;
                s2_sat_d   = alu_sat;
            end
        end

        // Clear wins over a same-cycle increment; the counter sticks at all-ones.
        if (sat_clr) begin
            sat_cnt_d = '0;
        end else if (out_fire && s2_sat_q && (sat_cnt_q != '1)) begin
            sat_cnt_d = sat_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q   <= 1'b0;
            s1_dat_q   <= '0;
            s1_prm_q   <= shifter_t'('0);
            s1_en_q    <= 1'b0;
            s2_vld_q   <= 1'b0;
            s2_color_q <= MIN_COLOR;
            s2_sat_q   <= 1'b0;
            sat_cnt_q  <= '0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            s1_dat_q   <= s1_dat_d;
            s1_prm_q   <= s1_prm_d;
            s1_en_q    <= s1_en_d;
            s2_vld_q   <= s2_vld_d;
            s2_color_q <= s2_color_d;
            s2_sat_q   <= s2_sat_d;
            sat_cnt_q  <= sat_cnt_d;
        end
    end

    assign in_ready  = in_rdy;
    assign out_valid = s2_vld_q;
    assign out_color = s2_color_q;
    assign out_sat   = s2_sat_q;
    assign sat_cnt   = sat_cnt_q;

endmodule

// File: tb/tb_shift_restore.sv
// Bench for shift_restore: directed corner cases plus random traffic against a queue-based model.
// Honours SHIFT_RESTORE_ROUND_EN when computing expected LEFT-inverse results.
module tb_shift_restore;
    import shift_restore_pkg::*;

    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    shifted_t      in_data;
    shifter_t      in_param;
    logic          in_en;
    logic          out_valid;
    logic          out_ready;
    color_t        out_color;
    logic          out_sat;
    logic [CW-1:0] sat_cnt;
    logic          sat_clr;

    shift_restore #(.SAT_CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_param  (in_param),
        .in_en     (in_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_color (out_color),
        .out_sat   (out_sat),
        .sat_cnt   (sat_cnt),
        .sat_clr   (sat_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int exp_q[$];
    int m_cnt = 0;
    int mon_e;
    int pd[3];
    int pdir[3];
    int pk[3];

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
        end
    endtask

    // Expected result as {sat, color[7:0]}, straight from the restoration rules.
    function automatic int ref_out(input int d, input int dir, input int k, input int en);
        int v;
        if (en == 0) begin
            v = d;
        end else if (dir == int'(ZERO)) begin
            return 0;
        end else if (dir == int'(RIGHT)) begin
            v = (k >= 1 && k <= 3) ? d * (1 << k) : d;
        end else begin
            if (k == 1 || k == 2) begin
`ifdef SHIFT_RESTORE_ROUND_EN
                v = (d + (1 << (k - 1))) / (1 << k);
`else
                v = d / (1 << k);
`endif
            end else begin
                v = d;
            end
        end
        if (v > 255) return 256 + 255;
        return v;
    endfunction

    // Observe handshakes mid-cycle; they take effect on the following rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_cnt = 0;
            chk("sat_cnt_rst", int'(sat_cnt), 0);
        end else begin
            chk("sat_cnt", int'(sat_cnt), m_cnt);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_output", 1, 0);
                    mon_e = 0;
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("out_color", int'(out_color), mon_e % 256);
                    chk("out_sat", int'(out_sat), mon_e / 256);
                end
                if (sat_clr) m_cnt = 0;
                else if ((mon_e / 256) == 1 && m_cnt < CMAX) m_cnt++;
            end else if (sat_clr) begin
                m_cnt = 0;
            end
            if (in_valid && in_ready)
                exp_q.push_back(ref_out(int'(in_data), int'(in_param.dir), int'(in_param.val), int'(in_en)));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int d, input int dir, input int k, input int en);
        in_data      = shifted_t'(d);
        in_param.dir = shift_dir_t'(dir[1:0]);
        in_param.val = k[1:0];
        in_en        = en[0];
    endtask

    task automatic send(input int d, input int dir, input int k, input int en);
        bit acc;
        acc = 1'b0;
        set_in(d, dir, k, en);
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !acc; i++) begin
            #1;
            acc = in_ready;
            step();
        end
        in_valid = 1'b0;
        if (!acc) chk("accept_timeout", 0, 1);
    endtask

    task automatic one(input string tag, input int d, input int dir, input int k, input int en,
                       input int ec, input int es);
        send(d, dir, k, en);
        chk({tag, "_early_valid"}, int'(out_valid), 0);
        step();
        chk({tag, "_valid"}, int'(out_valid), 1);
        chk({tag, "_color"}, int'(out_color), ec);
        chk({tag, "_sat"}, int'(out_sat), es);
        step();
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sat_clr   = 1'b0;
        set_in(0, 0, 0, 0);
        repeat (3) step();
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_color", int'(out_color), 0);
        chk("rst_out_sat", int'(out_sat), 0);
        chk("rst_sat_cnt", int'(sat_cnt), 0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        out_ready = 1'b1;
        step();

        one("left2", 'h0F0, int'(LEFT), 2, 1, 'h3C, 0);
        one("right3", 'h040, int'(RIGHT), 3, 1, 'hFF, 1);
        chk("sat_cnt_inc", int'(sat_cnt), 1);
`ifdef SHIFT_RESTORE_ROUND_EN
        one("left1_rnd", 'h007, int'(LEFT), 1, 1, 'h04, 0);
`else
        one("left1_trunc", 'h007, int'(LEFT), 1, 1, 'h03, 0);
`endif
        one("zero_dir", 'h2AB, int'(ZERO), 1, 1, 'h00, 0);
        one("bypass", 'h1A5, int'(RIGHT), 0, 0, 'hFF, 1);
        chk("sat_cnt_two", int'(sat_cnt), 2);

        // Three back-to-back offers against a stalled output.
        pd[0] = 'h0F0; pdir[0] = int'(LEFT);  pk[0] = 2;
        pd[1] = 'h010; pdir[1] = int'(RIGHT); pk[1] = 1;
        pd[2] = 'h003; pdir[2] = int'(RIGHT); pk[2] = 2;
        out_ready = 1'b0;
        begin
            int bi;
            bit acc;
            bi = 0;
            for (int c = 0; c < 4; c++) begin
                set_in(pd[bi], pdir[bi], pk[bi], 1);
                in_valid = 1'b1;
                #1;
                acc = in_ready;
                step();
                if (acc) bi++;
            end
            chk("bp_accepted", bi, 2);
        end
        #1;
        chk("bp_in_ready", int'(in_ready), 0);
        chk("bp_color", int'(out_color), 'h3C);
        step();
        step();
        chk("bp_hold_valid", int'(out_valid), 1);
        chk("bp_hold_color", int'(out_color), 'h3C);
        chk("bp_hold_sat", int'(out_sat), 0);
        out_ready = 1'b1;
        send(pd[2], pdir[2], pk[2], 1);
        repeat (4) step();
        chk("bp_drained", exp_q.size(), 0);

        // Push the counter to all-ones and one beyond.
        for (int i = 0; i < CMAX; i++) send('h3FF, int'(RIGHT), 1, 1);
        repeat (4) step();
        chk("sat_cnt_full", int'(sat_cnt), CMAX);
        send('h3FF, int'(RIGHT), 2, 1);
        repeat (4) step();
        chk("sat_cnt_stick", int'(sat_cnt), CMAX);

        send('h3FF, int'(RIGHT), 1, 1);
        step();
        chk("clr_pending_valid", int'(out_valid), 1);
        sat_clr = 1'b1;
        step();
        sat_clr = 1'b0;
        chk("sat_cnt_clr", int'(sat_cnt), 0);

        // Reset with two samples in flight.
        out_ready = 1'b0;
        send('h0F0, int'(LEFT), 2, 1);
        send('h040, int'(RIGHT), 3, 1);
        step();
        chk("inflight_valid", int'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_out_color", int'(out_color), 0);
        chk("midrst_sat_cnt", int'(sat_cnt), 0);
        step();
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("midrst_in_ready", int'(in_ready), 1);
        step();
        step();
        chk("midrst_no_ghost", int'(out_valid), 0);
        one("post_rst", 'h0F0, int'(LEFT), 2, 1, 'h3C, 0);

        // Random traffic, checked by the monitor.
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            sat_clr   = ($urandom_range(0, 49) == 0);
            set_in(int'($urandom_range(0, 1023)), int'($urandom_range(0, 2)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 7) != 0));
            step();
        end
        in_valid  = 1'b0;
        sat_clr   = 1'b0;
        out_ready = 1'b1;
        repeat (6) step();
        chk("final_drained", exp_q.size(), 0);
        chk("final_out_valid", int'(out_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/shift_restore.md
SHIFT_RESTORE -- requirements
Module: shift_restore

Interface
REQ-001 Parameter SAT_CNT_W, default 16, width of the saturation event counter.
REQ-002 clk  input  1  single clock for the whole block; all registers update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  in_data/in_param/in_en hold a valid sample.
REQ-005 in_ready  output  1  block accepts the sample this cycle.
REQ-006 in_data  input  shifted_t  shifted colour sample.
REQ-007 in_param  input  shifter_t  forward-shift setting (dir, val) that produced in_data.
REQ-008 in_en  input  1  forward shift was enabled; 0 means in_data is a bypassed colour.
REQ-009 out_valid  output  1  out_color is valid.
REQ-010 out_ready  input  1  downstream accepts out_color.
REQ-011 out_color  output  color_t  restored colour.
REQ-012 out_sat  output  1  out_color was clamped.
REQ-013 sat_cnt  output  SAT_CNT_W  count of accepted-at-output samples with out_sat=1.
REQ-014 sat_clr  input  1  synchronous clear of sat_cnt.

Function
REQ-015 Transfer occurs at an interface when valid and ready are both 1 on a rising clk edge.
REQ-016 Two-register pipeline: S1 captures the input; S2 holds the computed result and drives out_*. Latency is 2 cycles from input transfer to out_valid with no stall.
REQ-017 S2 loads when S2 is empty or the output transfers; S1 loads when S1 is empty or S1 advances into S2; in_ready = ~S1_valid | S1 advancing. Bubbles collapse.
REQ-018 Under out_ready=0 the block holds out_color, out_sat and out_valid stable and accepts at most 2 samples total.
REQ-019 Restoration rules (S1 -> S2): in_en=0: out = in_data saturated to MAX_COLOR; dir=LEFT by k: out = in_data >> k; dir=RIGHT by k: out = in_data << k, saturated to MAX_COLOR; dir=ZERO: out = MIN_COLOR, out_sat=0.
REQ-020 k follows the forward shift encoding: RIGHT accepts k in 1..3, LEFT in 1..2; any other k (including 0) is treated as shift 0, with saturation still applied.
REQ-021 Left shifts are computed at full width (shifted_t plus 3 bits) before clamping; no wrap-around.
REQ-022 out_sat = 1 iff the unclamped result exceeded MAX_COLOR.
REQ-023 sat_cnt increments by 1 on each output transfer with out_sat=1.
REQ-024 sat_cnt saturates at all-ones and does not wrap.
REQ-025 sat_clr has priority over a simultaneous increment: the result is 0.

Reset
REQ-026 While rst_n=0, the block forces S1_valid=0, S2_valid=0, out_valid=0, out_color=MIN_COLOR, out_sat=0, sat_cnt=0, and drives in_ready=1 once rst_n is released.
REQ-027 Reset asserted mid-operation discards in-flight samples without producing an output transfer; the first sample after release has the normal 2-cycle latency.

Configuration
REQ-028 When macro SHIFT_RESTORE_ROUND_EN is defined, LEFT-inverse right shifts round half-up: add 1<<(k-1) before shifting, then saturate to MAX_COLOR and flag out_sat.
REQ-029 When SHIFT_RESTORE_ROUND_EN is undefined, LEFT-inverse right shifts truncate.

Structure
REQ-030 The shared package pkg defines color_t (8 bits), shifted_t (10 bits), shifter_t {dir, val}, the direction enum {RIGHT, LEFT, ZERO}, shift_val_t (2 bits), N_COLOR_TO_SHIFTED=2, MIN_COLOR=0 and MAX_COLOR=255; the block defines no local duplicates of these.
REQ-031 The combinational restoration of REQ-019 to REQ-022 lives in the sub-module restore_alu; shift_restore instantiates it between S1 and S2 and holds all sequential logic.

Verification
REQ-032 in_data=10'h0F0, LEFT k=2, en=1, out_ready=1 -> out_color=8'h3C, out_sat=0, out_valid 2 cycles after accept.
REQ-033 in_data=10'h040, RIGHT k=3 -> out_color=8'hFF, out_sat=1, sat_cnt increments by 1.
REQ-034 in_data=10'h007, LEFT k=1: without the macro -> 8'h03; with SHIFT_RESTORE_ROUND_EN -> 8'h04.
REQ-035 3 back-to-back samples with out_ready=0 -> 2 are accepted and in_ready=0; on out_ready=1, outputs emerge in order with none lost or duplicated.
REQ-036 dir=ZERO -> out_color=8'h00; in_en=0 with in_data=10'h1A5 -> 8'hFF, out_sat=1.
REQ-037 sat_cnt at all-ones plus one saturating transfer -> remains all-ones; sat_clr together with a transfer -> 0; rst_n low with 2 in flight -> out_valid=0 with no transfer.
